rotl_seq_shifter: RTL
=====================

Name: rotl_seq_shifter

Overview:
- Sequential rotate-left engine: the opposite rotation direction to the existing combinational right-rotate barrel shifter.
- Accepts one data word plus a rotate amount over a valid/ready input handshake.
- Rotates left iteratively, one bit position per clock.
- Presents the result over a valid/ready output handshake. Used where a compact, multi-cycle left rotator is preferred over a full mux array.

Parameters:
- WIDTH, 8, data word width in bits; must equal 2**AMT_W.
- AMT_W, 3, rotate-amount width; legal amounts 0..WIDTH-1.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word and amount are valid
- in_ready  output  1  block can accept a new job
- in_data  input  WIDTH  word to rotate
- in_amt  input  AMT_W  left-rotate amount
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  rotated word
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, any state): state=IDLE, data_reg=0, cnt=0, in_ready=1, out_valid=0, out_data=0, busy=0. An in-flight job is discarded; no partial result is ever emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: data_reg<=in_data, cnt<=in_amt. Go to DONE if in_amt==0, else to SHIFT.
  - SHIFT: each cycle data_reg<={data_reg[WIDTH-2:0],data_reg[WIDTH-1]}, cnt<=cnt-1. When cnt==1 (last shift this cycle), go to DONE.
  - DONE: out_valid=1, out_data=data_reg. On out_ready, go to IDLE (out_valid drops next cycle).
- Handshake rules:
  - in_ready is combinational from state (IDLE only).
  - in_data and in_amt are ignored unless the transfer occurs.
  - out_data and out_valid stay stable while out_valid&&!out_ready.
  - in_valid may drop without a transfer; no state change results.
- Latency: out_valid rises amt+1 cycles after the accepting edge (amt=0 gives 1 cycle).
- Throughput: no overlap between jobs; the next accept is possible on the cycle after the out handshake. Minimum period is amt+2 cycles.
- Arithmetic: result equals in_data rotated left by in_amt mod WIDTH. No bits are lost. cnt never underflows.
- Simultaneous in_valid during SHIFT/DONE: not accepted (in_ready=0); the upstream holds.
- out_data outside DONE holds the last result (0 after reset).

Optional Feature:
- Macro ROTL_LOG_STEP_EN.
- Defined:
  - SHIFT always lasts exactly AMT_W cycles.
  - Step k (k=0..AMT_W-1) rotates left by 2**(AMT_W-1-k) if in_amt bit (AMT_W-1-k) is set, else holds.
  - in_amt==0 also passes through SHIFT.
  - Fixed latency: out_valid rises AMT_W+1 cycles after accept (4 for defaults).
- Undefined: one-bit-per-cycle behaviour as above. Results are bit-identical in both modes.

Test Plan:
- Reset, then in_data=8'hCC (11001100), in_amt=5, out_ready=1 -> out_valid 6 cycles after accept, out_data=8'b10011001 (8'h99).
- in_data=8'hA5, in_amt=0 -> out_valid 1 cycle after accept, out_data=8'hA5. Also in_data=8'h01, amt=7 -> 8'h80; in_data=8'h80, amt=1 -> 8'h01.
- Backpressure: 8'h3C, amt=2 with out_ready=0 for 3 cycles -> out_valid and out_data=8'hF0 held stable; in_ready=0 throughout; out_valid clears the cycle after out_ready=1.
- in_valid held high continuously with a second job during SHIFT -> second job accepted only in IDLE after the first handshake; both results correct and in order.
- Assert rst_n low mid-SHIFT (8'hCC, amt=5, after 2 shifts) -> immediately out_valid=0, out_data=0, in_ready=1, busy=0; no stale result after release.
- With ROTL_LOG_STEP_EN: sweep all 256 data values x 8 amounts -> every result matches the reference rotate; latency is always 4 cycles.

Source files
------------

// File: rtl/rotl_seq_shifter.sv
// Multi-cycle rotate-left engine with valid/ready on both sides.
// Optional macro ROTL_LOG_STEP_EN: fixed AMT_W-step log-shifter schedule instead of one bit per cycle.
module rotl_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends combinationally on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

`ifdef ROTL_LOG_STEP_EN
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] stp_q, stp_d;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic [AMT_W-1:0] s);
    logic [2*WIDTH-1:0] d;
    d = {x, x} << s;
    return d[2*WIDTH-1:WIDTH];
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
`ifdef ROTL_LOG_STEP_EN
    amt_d     = amt_q;
    stp_d     = stp_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = res_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = in_data;
`ifdef ROTL_LOG_STEP_EN
          // amount bits consumed MSB first, step size halves each cycle
          cnt_d   = AMT_W'(AMT_W);
          amt_d   = in_amt;
          stp_d   = {1'b1, {(AMT_W-1){1'b0}}};
          state_d = SHIFT;
`else
          cnt_d   = in_amt;
          state_d = (in_amt == '0) ? DONE : SHIFT;
`endif
        end
      end
      SHIFT: begin
`ifdef ROTL_LOG_STEP_EN
        if (amt_q[AMT_W-1]) data_d = rotl(data_q, stp_q);
        amt_d = amt_q << 1;
        stp_d = stp_q >> 1;
`else
        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) begin
          res_d   = data_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifdef ROTL_LOG_STEP_EN
      amt_q   <= '0;
      stp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef ROTL_LOG_STEP_EN
      amt_q   <= amt_d;
      stp_q   <= stp_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
